// File: rtl/dmu_sii_pkg.sv
// Shared definitions for the DMU-to-SII request scheduler.
//   - requester index enum (slot order used by the round-robin arbiter)
//   - header-cycle {datareq, datareq16} encodings
//   - write payload beat count
//   - FSM state encoding
//   - per-lane even parity helper for the 128-bit bus
package dmu_sii_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned WR_BEATS = 4;

  typedef enum logic [1:0] {
    REQ_RD    = 2'd0,
    REQ_WR    = 2'd1,
    REQ_MONDO = 2'd2,
    REQ_PIO   = 2'd3
  } req_idx_e;

  // {datareq, datareq16} driven in the header cycle
  localparam logic [1:0] RWM_RD = 2'b00;
  localparam logic [1:0] RWM_WR = 2'b10;
  localparam logic [1:0] RWM_SB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WPL  = 2'd1,
    ST_SPL  = 2'd2
  } state_e;

  // Even parity per 16-bit lane: bit i is the XOR of data[16i+15:16i].
  function automatic logic [7:0] lane_parity(input logic [127:0] d);
    logic [7:0] p;
    p = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      p[i] = ^d[16*i +: 16];
    end
    return p;
  endfunction

endpackage

// File: rtl/dmu_sii_rr_arb.sv
// Four-way round-robin arbiter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : arbitration allowed this cycle (bus free)
//   elig_i[3:0]  : eligible requesters (request pending and credit available)
//   gnt_o[3:0]   : one-hot grant, combinational
// The search starts at the pointer; after a grant the pointer moves to the
// slot following the winner. Reset pointer is slot 0.
module dmu_sii_rr_arb
  import dmu_sii_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] elig_i,
  output logic [3:0] gnt_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic [1:0] win;
  logic       found;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (en_i && found) begin
      gnt_o[win] = 1'b1;
    end
    ptr_d = (en_i && found) ? win + 2'd1 : ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmu_sii_req_sched.sv
// DMU-to-SII inbound bus sequencer/arbiter.
// Shares the single dmu_sii_* header/payload bus among DMA read (0),
// DMA write (1), mondo (2) and PIO completion (3) requesters.
// Ports:
//   iol2clk, rst            : clock, synchronous active-high reset
//   req_vld/req_gnt         : request pending / one-hot grant (comb, header captured)
//   req_bypass[1:0]         : bypass select for read [0] and write [1]
//   *_hdr                   : 128-bit header per requester
//   wr_data/wr_be/wr_pop    : write payload beat, byte enables, beat consumed
//   sb_data/sb_pop          : mondo/pio single payload beat, beat consumed
//   rd_credit_ret           : one DMA read credit returned
//   sii_dmu_wrack_vld       : one write/mondo credit returned
//   dmu_sii_*               : registered bus to SII
//   cred_err                : sticky credit-return overflow
module dmu_sii_req_sched
  import dmu_sii_pkg::*;
#(
  parameter int unsigned RD_CREDITS = 8,
  parameter int unsigned WR_CREDITS = 16
) (
  input  logic         iol2clk,
  input  logic         rst,
  input  logic [3:0]   req_vld,
  output logic [3:0]   req_gnt,
  input  logic [1:0]   req_bypass,
  input  logic [127:0] rd_hdr,
  input  logic [127:0] wr_hdr,
  input  logic [127:0] mondo_hdr,
  input  logic [127:0] pio_hdr,
  input  logic [127:0] wr_data,
  input  logic [15:0]  wr_be,
  output logic         wr_pop,
  input  logic [127:0] sb_data,
  output logic         sb_pop,
  input  logic         rd_credit_ret,
  input  logic         sii_dmu_wrack_vld,
  output logic         dmu_sii_hdr_vld,
  output logic         dmu_sii_reqbypass,
  output logic         dmu_sii_datareq,
  output logic         dmu_sii_datareq16,
  output logic [127:0] dmu_sii_data,
  output logic [7:0]   dmu_sii_parity,
  output logic [15:0]  dmu_sii_be,
  output logic         cred_err
);

  localparam int unsigned RDW = $clog2(RD_CREDITS + 1);
  localparam int unsigned WRW = $clog2(WR_CREDITS + 1);
  localparam logic [RDW-1:0] RD_MAX = RDW'(RD_CREDITS);
  localparam logic [WRW-1:0] WR_MAX = WRW'(WR_CREDITS);

  state_e         state_q;
  logic [1:0]     beat_q;
  logic           wr_pop_q, sb_pop_q;
  logic           hdr_vld_q, reqbypass_q, datareq_q, datareq16_q;
  logic [127:0]   data_q;
  logic [7:0]     par_q;
  logic [15:0]    be_q;

  logic [RDW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WRW-1:0] wr_cnt_q, wr_cnt_d;
  logic           cred_err_q, cred_err_d;

  logic [3:0]     elig;
  logic [3:0]     gnt;
  logic           arb_en;
  logic           rd_ok, wr_ok;
  logic           rd_take, wr_take;

  logic [127:0]   hdr_sel;
  logic [1:0]     enc_sel;
  logic           byp_sel;

  // ---------------------------------------------------------------- arbiter
  assign rd_ok  = (rd_cnt_q != '0);
  assign wr_ok  = (wr_cnt_q != '0);
  assign elig   = req_vld & {1'b1, wr_ok, wr_ok, rd_ok};
  assign arb_en = (state_q == ST_IDLE) && !rst;

  dmu_sii_rr_arb u_arb (
    .clk_i  (iol2clk),
    .rst_i  (rst),
    .en_i   (arb_en),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign req_gnt = gnt;

  // Header source and header-cycle encoding for the granted requester
  always_comb begin
    hdr_sel = '0;
    enc_sel = '0;
    byp_sel = 1'b0;
    if (gnt[REQ_RD]) begin
      hdr_sel = rd_hdr;
      enc_sel = RWM_RD;
      byp_sel = req_bypass[0];
    end else if (gnt[REQ_WR]) begin
      hdr_sel = wr_hdr;
      enc_sel = RWM_WR;
      byp_sel = req_bypass[1];
    end else if (gnt[REQ_MONDO]) begin
      hdr_sel = mondo_hdr;
      enc_sel = RWM_SB;
      byp_sel = 1'b0;
    end else if (gnt[REQ_PIO]) begin
      hdr_sel = pio_hdr;
      enc_sel = RWM_SB;
      byp_sel = 1'b1;
    end
  end

  // ---------------------------------------------------------------- credits
  assign rd_take = gnt[REQ_RD];
  assign wr_take = gnt[REQ_WR] | gnt[REQ_MONDO];

  // Consume and return in the same cycle cancel; a return at the reset
  // value saturates and flags an overflow.
  always_comb begin
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    cred_err_d = cred_err_q;
    if (rd_take && !rd_credit_ret) begin
      rd_cnt_d = rd_cnt_q - RDW'(1);
    end else if (!rd_take && rd_credit_ret) begin
      if (rd_cnt_q == RD_MAX) cred_err_d = 1'b1;
      else                    rd_cnt_d   = rd_cnt_q + RDW'(1);
    end
    if (wr_take && !sii_dmu_wrack_vld) begin
      wr_cnt_d = wr_cnt_q - WRW'(1);
    end else if (!wr_take && sii_dmu_wrack_vld) begin
      if (wr_cnt_q == WR_MAX) cred_err_d = 1'b1;
      else                    wr_cnt_d   = wr_cnt_q + WRW'(1);
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      rd_cnt_q   <= RD_MAX;
      wr_cnt_q   <= WR_MAX;
      cred_err_q <= 1'b0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      cred_err_q <= cred_err_d;
    end
  end

  // ---------------------------------------------------------------- FSM + bus
  // Pops are registered from the grant, so a popped beat is captured into
  // the bus register in the pop cycle and driven one cycle later.
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      wr_pop_q    <= 1'b0;
      sb_pop_q    <= 1'b0;
      hdr_vld_q   <= 1'b0;
      reqbypass_q <= 1'b0;
      datareq_q   <= 1'b0;
      datareq16_q <= 1'b0;
      data_q      <= '0;
      par_q       <= '0;
      be_q        <= '0;
    end else begin
      hdr_vld_q   <= 1'b0;
      reqbypass_q <= 1'b0;
      datareq_q   <= 1'b0;
      datareq16_q <= 1'b0;
      data_q      <= '0;
      par_q       <= '0;
      be_q        <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            hdr_vld_q                <= 1'b1;
            {datareq_q, datareq16_q} <= enc_sel;
            reqbypass_q              <= byp_sel;
            data_q                   <= hdr_sel;
            par_q                    <= lane_parity(hdr_sel);
            if (gnt[REQ_WR]) begin
              state_q  <= ST_WPL;
              beat_q   <= '0;
              wr_pop_q <= 1'b1;
            end else if (gnt[REQ_MONDO] || gnt[REQ_PIO]) begin
              state_q  <= ST_SPL;
              sb_pop_q <= 1'b1;
            end
          end
        end
        ST_WPL: begin
          data_q <= wr_data;
          par_q  <= lane_parity(wr_data);
          be_q   <= wr_be;
          if (beat_q == 2'(WR_BEATS - 1)) begin
            state_q  <= ST_IDLE;
            wr_pop_q <= 1'b0;
          end else begin
            beat_q <= beat_q + 2'd1;
          end
        end
        ST_SPL: begin
          data_q   <= sb_data;
          par_q    <= lane_parity(sb_data);
          state_q  <= ST_IDLE;
          sb_pop_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          wr_pop_q <= 1'b0;
          sb_pop_q <= 1'b0;
        end
      endcase
    end
  end

  assign wr_pop            = wr_pop_q;
  assign sb_pop            = sb_pop_q;
  assign dmu_sii_hdr_vld   = hdr_vld_q;
  assign dmu_sii_reqbypass = reqbypass_q;
  assign dmu_sii_datareq   = datareq_q;
  assign dmu_sii_datareq16 = datareq16_q;
  assign dmu_sii_data      = data_q;
  assign dmu_sii_parity    = par_q;
  assign dmu_sii_be        = be_q;
  assign cred_err          = cred_err_q;

endmodule

// File: tb/tb_dmu_sii_req_sched.sv
module tb_dmu_sii_req_sched;

  logic         iol2clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_vld = '0;
  logic [3:0]   req_gnt;
  logic [1:0]   req_bypass = '0;
  logic [127:0] rd_hdr = '0, wr_hdr = '0, mondo_hdr = '0, pio_hdr = '0;
  logic [127:0] wr_data = '0;
  logic [15:0]  wr_be = '0;
  logic         wr_pop;
  logic [127:0] sb_data = '0;
  logic         sb_pop;
  logic         rd_credit_ret = 1'b0;
  logic         sii_dmu_wrack_vld = 1'b0;
  logic         dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16;
  logic [127:0] dmu_sii_data;
  logic [7:0]   dmu_sii_parity;
  logic [15:0]  dmu_sii_be;
  logic         cred_err;

  int checks = 0;
  int errors = 0;

  always #5 iol2clk = ~iol2clk;

  dmu_sii_req_sched #(.RD_CREDITS(8), .WR_CREDITS(16)) dut (
    .iol2clk           (iol2clk),
    .rst               (rst),
    .req_vld           (req_vld),
    .req_gnt           (req_gnt),
    .req_bypass        (req_bypass),
    .rd_hdr            (rd_hdr),
    .wr_hdr            (wr_hdr),
    .mondo_hdr         (mondo_hdr),
    .pio_hdr           (pio_hdr),
    .wr_data           (wr_data),
    .wr_be             (wr_be),
    .wr_pop            (wr_pop),
    .sb_data           (sb_data),
    .sb_pop            (sb_pop),
    .rd_credit_ret     (rd_credit_ret),
    .sii_dmu_wrack_vld (sii_dmu_wrack_vld),
    .dmu_sii_hdr_vld   (dmu_sii_hdr_vld),
    .dmu_sii_reqbypass (dmu_sii_reqbypass),
    .dmu_sii_datareq   (dmu_sii_datareq),
    .dmu_sii_datareq16 (dmu_sii_datareq16),
    .dmu_sii_data      (dmu_sii_data),
    .dmu_sii_parity    (dmu_sii_parity),
    .dmu_sii_be        (dmu_sii_be),
    .cred_err          (cred_err)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge iol2clk);
    #1;
  endtask

  task automatic mid();
    @(negedge iol2clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_vld = '0;
    rd_credit_ret = 1'b0;
    sii_dmu_wrack_vld = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    mid();
    checks++;
    if ({req_gnt, wr_pop, sb_pop, dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq,
         dmu_sii_datareq16, cred_err} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0", {req_gnt, wr_pop, sb_pop, dmu_sii_hdr_vld,
               dmu_sii_reqbypass, dmu_sii_datareq, dmu_sii_datareq16, cred_err});
    end
    checks++;
    if ({dmu_sii_data, dmu_sii_parity, dmu_sii_be} !== 152'b0) begin
      errors++;
      $display("FAIL reset_bus: data=%h par=%h be=%h want 0", dmu_sii_data, dmu_sii_parity, dmu_sii_be);
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd8 || dut.wr_cnt_q !== 5'd16) begin
      errors++;
      $display("FAIL reset_cnt: rd=%0d wr=%0d want 8 16", dut.rd_cnt_q, dut.wr_cnt_q);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_read();
    rd_hdr = 128'h1234;
    req_bypass = 2'b01;
    req_vld = 4'b0001;
    mid();
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rd_gnt: got %b want 0001", req_gnt);
    end
    tick();
    req_vld = '0;
    mid();
    checks++;
    if ({dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 4'b1001) begin
      errors++;
      $display("FAIL rd_hdr_enc: got %b want 1001",
               {dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass});
    end
    checks++;
    if (dmu_sii_data !== 128'h1234 || dmu_sii_parity !== 8'h01 || dmu_sii_be !== 16'h0) begin
      errors++;
      $display("FAIL rd_hdr_bus: data=%h par=%h be=%h want 1234 01 0000",
               dmu_sii_data, dmu_sii_parity, dmu_sii_be);
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd7) begin
      errors++;
      $display("FAIL rd_cnt_consume: got %0d want 7", dut.rd_cnt_q);
    end
    // two reads back to back
    tick();
    req_bypass = 2'b00;
    req_vld = 4'b0001;
    mid();
    checks++;
    if (req_gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rd_b2b_gnt0: got %b want 0001", req_gnt);
    end
    tick();
    mid();
    checks++;
    if ({req_gnt, dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 8'b0001_1000) begin
      errors++;
      $display("FAIL rd_b2b_gnt1: got %b want 00011000",
               {req_gnt, dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass});
    end
    tick();
    req_vld = '0;
    mid();
    checks++;
    if (dmu_sii_hdr_vld !== 1'b1 || dut.rd_cnt_q !== 4'd5) begin
      errors++;
      $display("FAIL rd_b2b_hdr: hdr_vld=%b rd_cnt=%0d want 1 5", dmu_sii_hdr_vld, dut.rd_cnt_q);
    end
    rd_credit_ret = 1'b1;
    repeat (3) tick();
    rd_credit_ret = 1'b0;
    mid();
    checks++;
    if (dut.rd_cnt_q !== 4'd8) begin
      errors++;
      $display("FAIL rd_cnt_return: got %0d want 8", dut.rd_cnt_q);
    end
    tick();
  endtask

  task automatic test_write();
    logic [7:0] par_tab [4];
    par_tab = '{8'h00, 8'h01, 8'h00, 8'h01};
    wr_hdr = {16'h0001, 96'h0, 16'h0003};
    req_bypass = 2'b00;
    req_vld = 4'b0010;
    mid();
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL wr_gnt: got %b want 0010", req_gnt);
    end
    tick();
    req_vld = '0;
    for (int j = 0; j < 5; j++) begin
      wr_data = 128'hA + 128'(j);
      wr_be = 16'hFFFF;
      mid();
      checks++;
      if (wr_pop !== (j < 4)) begin
        errors++;
        $display("FAIL wr_pop_%0d: got %b want %b", j, wr_pop, (j < 4));
      end
      if (j == 0) begin
        checks++;
        if ({dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 4'b1100 ||
            dmu_sii_data !== {16'h0001, 96'h0, 16'h0003} || dmu_sii_parity !== 8'h80 ||
            dmu_sii_be !== 16'h0 || dut.wr_cnt_q !== 5'd15) begin
          errors++;
          $display("FAIL wr_hdr: enc=%b data=%h par=%h be=%h cnt=%0d want 1100 hdr 80 0000 15",
                   {dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass},
                   dmu_sii_data, dmu_sii_parity, dmu_sii_be, dut.wr_cnt_q);
        end
      end else begin
        checks++;
        if ({dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16} !== 3'b000 ||
            dmu_sii_data !== 128'hA + 128'(j - 1) || dmu_sii_be !== 16'hFFFF ||
            dmu_sii_parity !== par_tab[j-1]) begin
          errors++;
          $display("FAIL wr_beat_%0d: ctl=%b data=%h be=%h par=%h want 000 %h ffff %h", j - 1,
                   {dmu_sii_hdr_vld, dmu_sii_datareq, dmu_sii_datareq16}, dmu_sii_data,
                   dmu_sii_be, dmu_sii_parity, 128'hA + 128'(j - 1), par_tab[j-1]);
        end
      end
      tick();
    end
    mid();
    checks++;
    if (dmu_sii_hdr_vld !== 1'b0 || dmu_sii_be !== 16'h0 || dmu_sii_data !== '0 || wr_pop !== 1'b0) begin
      errors++;
      $display("FAIL wr_after: hdr=%b be=%h data=%h pop=%b want 0", dmu_sii_hdr_vld, dmu_sii_be,
               dmu_sii_data, wr_pop);
    end
    tick();
    sii_dmu_wrack_vld = 1'b1;
    tick();
    sii_dmu_wrack_vld = 1'b0;
    mid();
    checks++;
    if (dut.wr_cnt_q !== 5'd16 || cred_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_wrack: cnt=%0d err=%b want 16 0", dut.wr_cnt_q, cred_err);
    end
    tick();
  endtask

  task automatic test_round_robin();
    // {gnt[3:0], hdr_vld, wr_pop, sb_pop} per cycle
    logic [6:0] exp_ctl [12];
    exp_ctl = '{7'b0001_000, 7'b0010_100, 7'b0000_110, 7'b0000_010, 7'b0000_010, 7'b0000_010,
                7'b0100_000, 7'b0000_101, 7'b1000_000, 7'b0000_101, 7'b0001_000, 7'b0010_100};
    apply_reset();
    rd_hdr = 128'h1;
    wr_hdr = 128'h2;
    mondo_hdr = 128'h3;
    pio_hdr = 128'h4;
    sb_data = 128'hBEEF;
    req_bypass = 2'b11;
    req_vld = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      mid();
      checks++;
      if ({req_gnt, dmu_sii_hdr_vld, wr_pop, sb_pop} !== exp_ctl[c]) begin
        errors++;
        $display("FAIL rr_cycle_%0d: got %b want %b", c, {req_gnt, dmu_sii_hdr_vld, wr_pop, sb_pop}, exp_ctl[c]);
      end
      if (c == 2) begin
        checks++;
        if ({dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 3'b101 || dmu_sii_data !== 128'h2) begin
          errors++;
          $display("FAIL rr_wr_hdr: enc=%b data=%h want 101 2",
                   {dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass}, dmu_sii_data);
        end
      end
      if (c == 7) begin
        checks++;
        if ({dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 3'b110 || dmu_sii_data !== 128'h3) begin
          errors++;
          $display("FAIL rr_mondo_hdr: enc=%b data=%h want 110 3",
                   {dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass}, dmu_sii_data);
        end
      end
      if (c == 8) begin
        checks++;
        if (dmu_sii_data !== 128'hBEEF || dmu_sii_be !== 16'h0) begin
          errors++;
          $display("FAIL rr_sb_beat: data=%h be=%h want beef 0000", dmu_sii_data, dmu_sii_be);
        end
      end
      if (c == 9) begin
        checks++;
        if ({dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass} !== 3'b111 || dmu_sii_data !== 128'h4) begin
          errors++;
          $display("FAIL rr_pio_hdr: enc=%b data=%h want 111 4",
                   {dmu_sii_datareq, dmu_sii_datareq16, dmu_sii_reqbypass}, dmu_sii_data);
        end
      end
      tick();
    end
    req_vld = '0;
    repeat (8) tick();
  endtask

  task automatic test_credit_exhaust();
    int nw = 0;
    int np = 0;
    int cyc = 0;
    apply_reset();
    req_vld = 4'b1010;
    while (nw < 16 && cyc < 400) begin
      mid();
      if (req_gnt[1]) nw++;
      tick();
      cyc++;
    end
    checks++;
    if (nw != 16) begin
      errors++;
      $display("FAIL ex_16_writes: got %0d writes in %0d cycles want 16", nw, cyc);
    end
    nw = 0;
    for (int c = 0; c < 30; c++) begin
      mid();
      if (req_gnt[1]) nw++;
      if (req_gnt[3]) np++;
      tick();
    end
    checks++;
    if (nw != 0 || np < 10 || dut.wr_cnt_q !== 5'd0) begin
      errors++;
      $display("FAIL ex_stall: writes=%0d pio=%0d cnt=%0d want 0 >=10 0", nw, np, dut.wr_cnt_q);
    end
    req_vld = 4'b0010;
    repeat (4) tick();
    sii_dmu_wrack_vld = 1'b1;
    mid();
    checks++;
    if (req_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL ex_wrack_cycle: got %b want 0000", req_gnt);
    end
    tick();
    sii_dmu_wrack_vld = 1'b0;
    mid();
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL ex_wr_after_wrack: got %b want 0010", req_gnt);
    end
    tick();
    req_vld = '0;
    repeat (6) tick();
  endtask

  task automatic test_credit_collision();
    int nw = 0;
    int cyc = 0;
    apply_reset();
    req_vld = 4'b0010;
    while (nw < 11 && cyc < 200) begin
      mid();
      if (req_gnt[1]) nw++;
      tick();
      cyc++;
    end
    req_vld = '0;
    repeat (6) tick();
    mid();
    checks++;
    if (dut.wr_cnt_q !== 5'd5) begin
      errors++;
      $display("FAIL col_setup: cnt=%0d want 5", dut.wr_cnt_q);
    end
    tick();
    req_vld = 4'b0010;
    sii_dmu_wrack_vld = 1'b1;
    mid();
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL col_gnt: got %b want 0010", req_gnt);
    end
    tick();
    req_vld = '0;
    sii_dmu_wrack_vld = 1'b0;
    mid();
    checks++;
    if (dut.wr_cnt_q !== 5'd5) begin
      errors++;
      $display("FAIL col_cnt: got %0d want 5", dut.wr_cnt_q);
    end
    sii_dmu_wrack_vld = 1'b1;
    repeat (11) tick();
    sii_dmu_wrack_vld = 1'b0;
    mid();
    checks++;
    if (dut.wr_cnt_q !== 5'd16 || cred_err !== 1'b0) begin
      errors++;
      $display("FAIL col_full: cnt=%0d err=%b want 16 0", dut.wr_cnt_q, cred_err);
    end
    sii_dmu_wrack_vld = 1'b1;
    tick();
    sii_dmu_wrack_vld = 1'b0;
    mid();
    checks++;
    if (dut.wr_cnt_q !== 5'd16 || cred_err !== 1'b1) begin
      errors++;
      $display("FAIL col_overflow: cnt=%0d err=%b want 16 1", dut.wr_cnt_q, cred_err);
    end
    repeat (3) tick();
    mid();
    checks++;
    if (cred_err !== 1'b1) begin
      errors++;
      $display("FAIL col_err_sticky: got %b want 1", cred_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    wr_be = 16'h00FF;
    req_vld = 4'b0010;
    mid();
    checks++;
    if (req_gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rstw_gnt: got %b want 0010", req_gnt);
    end
    tick();
    req_vld = '0;
    mid();
    checks++;
    if (wr_pop !== 1'b1) begin
      errors++;
      $display("FAIL rstw_pop1: got %b want 1", wr_pop);
    end
    tick();
    rst = 1'b1;
    mid();
    checks++;
    if (wr_pop !== 1'b1 || dmu_sii_be !== 16'h00FF) begin
      errors++;
      $display("FAIL rstw_pop2: pop=%b be=%h want 1 00ff", wr_pop, dmu_sii_be);
    end
    tick();
    rst = 1'b0;
    mid();
    checks++;
    if ({req_gnt, wr_pop, sb_pop, dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq,
         dmu_sii_datareq16, cred_err} !== 10'b0 || dmu_sii_data !== '0 ||
        dmu_sii_parity !== 8'h0 || dmu_sii_be !== 16'h0) begin
      errors++;
      $display("FAIL rstw_outputs: ctl=%b data=%h par=%h be=%h want 0",
               {req_gnt, wr_pop, sb_pop, dmu_sii_hdr_vld, dmu_sii_reqbypass, dmu_sii_datareq,
                dmu_sii_datareq16, cred_err}, dmu_sii_data, dmu_sii_parity, dmu_sii_be);
    end
    checks++;
    if (dut.rd_cnt_q !== 4'd8 || dut.wr_cnt_q !== 5'd16) begin
      errors++;
      $display("FAIL rstw_cnt: rd=%0d wr=%0d want 8 16", dut.rd_cnt_q, dut.wr_cnt_q);
    end
    tick();
    mid();
    checks++;
    if ({wr_pop, sb_pop, dmu_sii_hdr_vld, dmu_sii_be} !== 19'b0) begin
      errors++;
      $display("FAIL rstw_no_pop: got %b want 0", {wr_pop, sb_pop, dmu_sii_hdr_vld, dmu_sii_be});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_credit_exhaust();
    test_credit_collision();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
